tx232_frame: RTL and testbench
==============================

TX232_FRAME -- requirements
Module: tx232_frame

Interface
REQ-001 NBYTES, 2, payload byte count per frame, legal range 1..16.
REQ-002 MSB_FIRST, 1, 1 = send the most significant byte first, 0 = send the least significant byte first.
REQ-003 GAP_BITS, 0, idle txck periods inserted between bytes, legal range 0..15.
REQ-004 clk  input  1  system clock; every flop is on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 data  input  NBYTES*8  payload word, captured at frame start.
REQ-007 start  input  1  frame request; a rising edge requests a frame.
REQ-008 txck  input  1  bit-rate clock, asynchronous to clk, sampled on clk.
REQ-009 txpd  output  8  byte currently presented to the serialiser.
REQ-010 tnpd  output  1  byte-load strobe window for the serialiser.
REQ-011 busy  output  1  high while a frame is in progress.
REQ-012 done  output  1  one-clk pulse at frame completion.

Function
REQ-013 txck SHALL pass through a 2-flop delay; txck_r = d0 & ~d1 and txck_f = ~d0 & d1.
REQ-014 start SHALL be shifted into a 2-bit history only on txck_f; start_r = h0 & ~h1.
REQ-015 The FSM SHALL have states IDLE, SEND, GAP and CHK, and SHALL advance only on txck_r.
REQ-016 In IDLE, on txck_r with start_r = 1, the block SHALL capture data into ibcd, clear bcnt and bycnt, set busy, and enter SEND.
REQ-017 If start_r occurs while busy = 1, the block SHALL ignore it; the frame in progress continues unaltered.
REQ-018 In SEND, bcnt SHALL count 0..9 on txck_r, giving one byte per 10 txck periods.
REQ-019 On txck_r in SEND, txpd SHALL load the selected byte of ibcd.
- Byte selection: byte index bycnt, counted from the MSB end if MSB_FIRST = 1, else from the LSB end.
REQ-020 On txck_r, tnpd SHALL be set to (3 < bcnt+1 <= 8) evaluated on the pre-increment bcnt, i.e. high for exactly 5 txck periods per byte and low otherwise.
REQ-021 At bcnt = 9 with more bytes pending, the FSM SHALL increment bycnt and go to GAP if GAP_BITS > 0, else go straight to bcnt = 0 of the next byte.
REQ-022 In GAP, the FSM SHALL hold txpd = 8'hff and tnpd = 0 for GAP_BITS txck periods, then return to SEND with bcnt = 0.
REQ-023 At bcnt = 9 of the last byte, the FSM SHALL go to CHK if the macro is defined, else to IDLE.
REQ-024 On entering IDLE from a frame, the block SHALL pulse done high for one clk and clear busy in the same cycle.
REQ-025 In IDLE, txpd SHALL be 8'hff and tnpd SHALL be 0.
REQ-026 bycnt SHALL be $clog2(NBYTES+1) bits wide, SHALL never wrap, and SHALL saturate at its last index.

Reset
REQ-027 On rst low, regardless of any operation in progress, the block SHALL set:
- state = IDLE, txpd = 8'hff, tnpd = 0, busy = 0, done = 0;
- bcnt = 4'hf, bycnt = 0, ibcd = all ones;
- txck and start history registers = 0.
REQ-028 After reset release, no frame SHALL start until a fresh start rising edge is detected.

Configuration
REQ-029 TX232_FRAME_CHKSUM_EN defined: after the last payload byte, the block SHALL send one extra byte equal to the modulo-256 sum of all payload bytes.
- This byte uses the same 10-period timing and tnpd window as a payload byte.
- The GAP rule applies before it.
REQ-030 TX232_FRAME_CHKSUM_EN undefined: CHK and the sum register SHALL be absent, and the frame SHALL be exactly NBYTES bytes.

Structure
REQ-031 The shared package tx232_pkg SHALL hold:
- the FSM state enum;
- the constants BCNT_LAST = 9, TNPD_LO = 3, TNPD_HI = 7 and IDLE_BYTE = 8'hff.
REQ-032 The txck edge detector SHALL be the sub-module tx232_edge, with outputs rise and fall.

Verification
REQ-033 NBYTES = 2, data = 16'h1234, one start pulse -> txpd 8'h12 then 8'h34, tnpd high for 5 txck periods per byte, one done pulse, then busy = 0.
REQ-034 MSB_FIRST = 0, same stimulus -> byte order 8'h34 then 8'h12.
REQ-035 TX232_FRAME_CHKSUM_EN defined, data = 16'h1234 -> third byte 8'h46; data = 16'hFF02 -> third byte 8'h01 (wrap-around).
REQ-036 GAP_BITS = 3 -> exactly 3 txck periods between bytes with txpd = 8'hff and tnpd = 0.
REQ-037 A second start edge during byte 0 -> ignored, and exactly one frame is sent.
REQ-038 rst asserted during byte 1 -> txpd = 8'hff, tnpd = 0, busy = 0 immediately, and no done pulse.

Source files
------------

// File: rtl/tx232_pkg.sv
// Shared types and constants for the tx232 byte framer.
// TX232_FRAME_CHKSUM_EN adds the CHK state for the trailing checksum byte.
package tx232_pkg;

`ifdef TX232_FRAME_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif

  localparam logic [3:0] BCNT_LAST = 4'd9;
  localparam logic [3:0] TNPD_LO   = 4'd3;
  localparam logic [3:0] TNPD_HI   = 4'd7;
  localparam logic [3:0] BCNT_RST  = 4'hf;
  localparam logic [7:0] IDLE_BYTE = 8'hff;

endpackage

// File: rtl/tx232_frame_if.sv
// Framer bus: payload/request/bit clock in, serialiser byte, strobe and status out.
interface tx232_frame_if #(parameter int NBYTES = 2);
  logic [NBYTES*8-1:0] data;
  logic                start;
  logic                txck;
  logic [7:0]          txpd;
  logic                tnpd;
  logic                busy;
  logic                done;

  modport master (output data, start, txck, input txpd, tnpd, busy, done);
  modport slave  (input data, start, txck, output txpd, tnpd, busy, done);
endinterface

// File: rtl/tx232_edge.sv
// Two-flop delay of an asynchronous clock-like input with single-cycle edge strobes.
module tx232_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic d0, d1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d0 <= 1'b0;
      d1 <= 1'b0;
    end else begin
      d0 <= din;
      d1 <= d0;
    end
  end

  assign rise = d0 & ~d1;
  assign fall = ~d0 & d1;
endmodule

// File: rtl/tx232_frame.sv
// Frames an NBYTES payload into 10-txck byte slots with a 5-period tnpd load window.
// Optional trailing mod-256 checksum byte when TX232_FRAME_CHKSUM_EN is defined.
module tx232_frame
  import tx232_pkg::*;
#(
  parameter int NBYTES    = 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP_BITS  = 0
) (
  input logic         clk,
  input logic         rst,
  tx232_frame_if.slave bus
);
  localparam int BYW = $clog2(NBYTES + 1);
  localparam logic [BYW-1:0] BY_PAY_LAST = BYW'(NBYTES - 1);
`ifdef TX232_FRAME_CHKSUM_EN
  localparam logic [BYW-1:0] BY_LAST = BYW'(NBYTES);
`else
  localparam logic [BYW-1:0] BY_LAST = BYW'(NBYTES - 1);
`endif
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

  state_t state, state_nxt;
  logic   txck_r, txck_f;
  logic [1:0] hist;
  logic   start_r, frame_go;
  logic [NBYTES*8-1:0] ibcd;
  logic [3:0]     bcnt, bcnt_nxt;
  logic [BYW-1:0] bycnt, bycnt_nxt;
  logic [7:0]     txpd, txpd_nxt, sel_byte, byte_out;
  logic           tnpd, tnpd_nxt, busy, busy_nxt, done, done_nxt;
`ifdef TX232_FRAME_CHKSUM_EN
  logic [7:0]     sum, sum_in;
`endif

  tx232_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.txck),
    .rise (txck_r),
    .fall (txck_f)
  );

  assign start_r  = hist[0] & ~hist[1];
  assign frame_go = txck_r & start_r & (state == IDLE);

  always_comb begin
    sel_byte = IDLE_BYTE;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (bycnt == BYW'(i))
        sel_byte = MSB_FIRST ? ibcd[(NBYTES-1-i)*8 +: 8] : ibcd[i*8 +: 8];
    end
  end

`ifdef TX232_FRAME_CHKSUM_EN
  always_comb begin
    sum_in = '0;
    for (int unsigned i = 0; i < NBYTES; i++) sum_in = sum_in + bus.data[i*8 +: 8];
  end
  assign byte_out = (state == CHK) ? sum : sel_byte;
`else
  assign byte_out = sel_byte;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (txck_r) begin
      case (state)
        IDLE: if (start_r) state_nxt = SEND;
        SEND: begin
          if (bcnt == BCNT_LAST) begin
            if (bycnt != BY_PAY_LAST)
              state_nxt = (GAP_BITS > 0) ? GAP : SEND;
            else begin
`ifdef TX232_FRAME_CHKSUM_EN
              state_nxt = (GAP_BITS > 0) ? GAP : CHK;
`else
              state_nxt = IDLE;
`endif
            end
          end
        end
        GAP: begin
          if (bcnt == GAP_LAST) begin
`ifdef TX232_FRAME_CHKSUM_EN
            state_nxt = (bycnt == BY_LAST) ? CHK : SEND;
`else
            state_nxt = SEND;
`endif
          end
        end
`ifdef TX232_FRAME_CHKSUM_EN
        CHK: if (bcnt == BCNT_LAST) state_nxt = IDLE;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // bcnt doubles as the gap-period counter while in GAP.
  always_comb begin
    bcnt_nxt  = bcnt;
    bycnt_nxt = bycnt;
    txpd_nxt  = txpd;
    tnpd_nxt  = tnpd;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    if (txck_r) begin
      case (state)
        IDLE: begin
          if (start_r) begin
            bcnt_nxt  = '0;
            bycnt_nxt = '0;
            busy_nxt  = 1'b1;
          end
        end
        GAP: begin
          txpd_nxt = IDLE_BYTE;
          tnpd_nxt = 1'b0;
          bcnt_nxt = (bcnt == GAP_LAST) ? '0 : bcnt + 4'd1;
        end
        default: begin
          txpd_nxt = byte_out;
          tnpd_nxt = (bcnt >= TNPD_LO) && (bcnt <= TNPD_HI);
          if (bcnt == BCNT_LAST) begin
            bcnt_nxt = '0;
            if (bycnt != BY_LAST) bycnt_nxt = bycnt + 1'b1;
          end else begin
            bcnt_nxt = bcnt + 4'd1;
          end
        end
      endcase
      if (state != IDLE && state_nxt == IDLE) begin
        txpd_nxt = IDLE_BYTE;
        tnpd_nxt = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist  <= '0;
      ibcd  <= '1;
      bcnt  <= BCNT_RST;
      bycnt <= '0;
      txpd  <= IDLE_BYTE;
      tnpd  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef TX232_FRAME_CHKSUM_EN
      sum   <= '0;
`endif
    end else begin
      if (txck_f) hist <= {hist[0], bus.start};
      if (frame_go) begin
        ibcd <= bus.data;
`ifdef TX232_FRAME_CHKSUM_EN
        sum  <= sum_in;
`endif
      end
      bcnt  <= bcnt_nxt;
      bycnt <= bycnt_nxt;
      txpd  <= txpd_nxt;
      tnpd  <= tnpd_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  assign bus.txpd = txpd;
  assign bus.tnpd = tnpd;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_tx232_frame.sv
// Directed bench for tx232_frame: MSB-first/no-gap and LSB-first/3-gap instances,
// byte values read inside each tnpd window of a per-txck-period trace.
module tb_tx232_frame;
`ifdef TX232_FRAME_CHKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int NS = 64;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic txck = 1'b0;
  always #5  clk  = ~clk;
  always #40 txck = ~txck;

  tx232_frame_if #(.NBYTES(2)) bus0 ();
  tx232_frame_if #(.NBYTES(2)) bus1 ();
  assign bus0.txck = txck;
  assign bus1.txck = txck;

  tx232_frame #(.NBYTES(2), .MSB_FIRST(1'b1), .GAP_BITS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  tx232_frame #(.NBYTES(2), .MSB_FIRST(1'b0), .GAP_BITS(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int          d;
    logic [15:0] data;
    logic [23:0] exp;     // expected bytes in send order, first byte in [23:16]
    int          gap;
    bit          chkgap;  // gap measurable only when no adjacent byte is 8'hff
  } vec_t;
  vec_t vt [6];

  int checks = 0;
  int errors = 0;
  int dcnt0 = 0, dcnt1 = 0;
  always @(negedge clk) begin
    if (bus0.done) dcnt0++;
    if (bus1.done) dcnt1++;
  end

  logic [7:0] s_txpd [NS];
  logic       s_tnpd [NS];
  logic       s_busy [NS];
  int ns, nb, first_on, done_got;
  logic [7:0] bv [8];
  int rl [8];
  int gf [8];

  function automatic logic [7:0] txpd_of(input int d);
    return (d == 0) ? bus0.txpd : bus1.txpd;
  endfunction
  function automatic logic tnpd_of(input int d);
    return (d == 0) ? bus0.tnpd : bus1.tnpd;
  endfunction
  function automatic logic busy_of(input int d);
    return (d == 0) ? bus0.busy : bus1.busy;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) bus0.start = v;
    else        bus1.start = v;
  endtask

  task automatic run_frame(input int d, input logic [15:0] dat, input int nper, input bit dbl);
    int base;
    if (d == 0) bus0.data = dat;
    else        bus1.data = dat;
    @(negedge txck); #1;
    base = (d == 0) ? dcnt0 : dcnt1;
    set_start(d, 1'b1);
    for (int p = 0; p < nper; p++) begin
      @(negedge txck); #1;
      s_txpd[p] = txpd_of(d);
      s_tnpd[p] = tnpd_of(d);
      s_busy[p] = busy_of(d);
      if (p == 1) set_start(d, 1'b0);
      if (dbl && p == 3) set_start(d, 1'b1);
      if (dbl && p == 5) set_start(d, 1'b0);
    end
    ns = nper;
    done_got = ((d == 0) ? dcnt0 : dcnt1) - base;
  endtask

  // Splits the trace into tnpd windows: byte value, window length, idle periods before it.
  task automatic analyze();
    bit prev;
    int ffc;
    nb = 0; ffc = 0; prev = 1'b0; first_on = -1;
    for (int p = 0; p < ns; p++) begin
      if (s_tnpd[p]) begin
        if (!prev && nb < 8) begin
          bv[nb] = s_txpd[p];
          rl[nb] = 0;
          gf[nb] = ffc;
          if (first_on < 0) first_on = p;
        end
        if (nb < 8) rl[nb]++;
      end else begin
        if (prev) begin
          nb++;
          ffc = 0;
        end
        if (s_txpd[p] == 8'hff) ffc++;
      end
      prev = s_tnpd[p];
    end
    if (prev) nb++;
  endtask

  initial begin
    int rises, cyc, tn_hi, bz_hi, base;
    bit pv;
    logic [7:0] eb;

    bus0.start = 1'b0; bus0.data = '0;
    bus1.start = 1'b0; bus1.data = '0;
    vt[0] = '{0, 16'h1234, 24'h123446, 0, 1'b1};
    vt[1] = '{1, 16'h1234, 24'h341246, 3, 1'b1};
    vt[2] = '{0, 16'hFF02, 24'hFF0201, 0, 1'b0};
    vt[3] = '{1, 16'hA5C3, 24'hC3A568, 3, 1'b1};
    vt[4] = '{0, 16'h0000, 24'h000000, 0, 1'b1};
    vt[5] = '{1, 16'hFF02, 24'h02FF01, 3, 1'b0};

    #23 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_txpd0", int'(bus0.txpd), 8'hff);
    chk("rst_tnpd0", int'(bus0.tnpd), 0);
    chk("rst_busy0", int'(bus0.busy), 0);
    chk("rst_done0", int'(bus0.done), 0);
    chk("rst_txpd1", int'(bus1.txpd), 8'hff);
    chk("rst_tnpd1", int'(bus1.tnpd), 0);
    chk("rst_busy1", int'(bus1.busy), 0);
    chk("rst_done1", int'(bus1.done), 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vt[i].d, vt[i].data, 50, 1'b0);
      analyze();
      chk($sformatf("vec%0d_nbytes", i), nb, NB);
      for (int k = 0; k < NB; k++) begin
        eb = vt[i].exp[23-8*k -: 8];
        chk($sformatf("vec%0d_byte%0d", i, k), int'(bv[k]), int'(eb));
        chk($sformatf("vec%0d_tnpd_len%0d", i, k), rl[k], 5);
        if (vt[i].chkgap && k > 0)
          chk($sformatf("vec%0d_gap%0d", i, k), gf[k], vt[i].gap);
      end
      chk($sformatf("vec%0d_done", i), done_got, 1);
      chk($sformatf("vec%0d_busy_mid", i), (first_on >= 0) ? int'(s_busy[first_on]) : 0, 1);
      chk($sformatf("vec%0d_busy_end", i), int'(s_busy[ns-1]), 0);
      chk($sformatf("vec%0d_txpd_end", i), int'(s_txpd[ns-1]), 8'hff);
      chk($sformatf("vec%0d_tnpd_end", i), int'(s_tnpd[ns-1]), 0);
    end

    // Second start edge inside byte 0 must not disturb or repeat the frame.
    run_frame(0, 16'h1234, 60, 1'b1);
    analyze();
    chk("dbl_nbytes", nb, NB);
    chk("dbl_byte0", int'(bv[0]), 8'h12);
    chk("dbl_byte1", int'(bv[1]), 8'h34);
    chk("dbl_tnpd_len0", rl[0], 5);
    chk("dbl_done", done_got, 1);

    // Reset in the middle of byte 1's tnpd window.
    bus0.data = 16'h1234;
    @(negedge txck); #1;
    bus0.start = 1'b1;
    @(negedge txck); #1;
    @(negedge txck); #1;
    bus0.start = 1'b0;
    rises = 0; cyc = 0; pv = 1'b0;
    while (rises < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus0.tnpd && !pv) rises++;
      pv = bus0.tnpd;
    end
    chk("rst_wait_byte1", rises, 2);
    repeat (24) @(negedge clk);
    chk("pre_rst_tnpd", int'(bus0.tnpd), 1);
    chk("pre_rst_busy", int'(bus0.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_txpd", int'(bus0.txpd), 8'hff);
    chk("mid_rst_tnpd", int'(bus0.tnpd), 0);
    chk("mid_rst_busy", int'(bus0.busy), 0);
    base = dcnt0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    tn_hi = 0; bz_hi = 0;
    for (int p = 0; p < 30; p++) begin
      @(negedge txck); #1;
      if (bus0.tnpd) tn_hi++;
      if (bus0.busy) bz_hi++;
    end
    chk("post_rst_done", dcnt0 - base, 0);
    chk("post_rst_tnpd", tn_hi, 0);
    chk("post_rst_busy", bz_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
